// File: rtl/dcpu16_opf.sv
// dcpu16_opf: DCPU16 operand-fetch unit resolving the a and b value codes of one instruction
//   clk/rst/ena               clock, async active-high reset, stage enable (low = freeze)
//   ins/ins_vld/ins_rdy       instruction handshake from fetch
//   rra/rrd                   register-file read port
//   pc/sp/regO                architectural registers sampled for nw/stack/literal modes
//   ab_adr/ab_stb/ab_ack/ab_dti  bus read port
//   pc_inc/sp_inc/sp_dec      single-cycle side-effect pulses
//   opc/regA/regB/ea/ea_mem/acd/op_vld/op_rdy  resolved operands to the ALU
//   err                       sticky bus timeout flag
module dcpu16_opf #(
  parameter int BUS_TMO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [15:0] ins,
  input  logic        ins_vld,
  output logic        ins_rdy,
  output logic [2:0]  rra,
  input  logic [15:0] rrd,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  input  logic [15:0] regO,
  output logic [15:0] ab_adr,
  output logic        ab_stb,
  input  logic        ab_ack,
  input  logic [15:0] ab_dti,
  output logic        pc_inc,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic [3:0]  opc,
  output logic [15:0] regA,
  output logic [15:0] regB,
  output logic [15:0] ea,
  output logic        ea_mem,
  output logic [5:0]  acd,
  output logic        op_vld,
  input  logic        op_rdy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, DA, ANX, AMEM, DB, BNX, BMEM, OUT} state_t;
  state_t state, nxt, nx_s, mem_s;
  logic [15:0] ins_r, adr, adr_n, v, d;
  logic [31:0] cnt;
  logic [5:0] c;
  logic k, fin, sb, dec, nx, mem, bus, tmo, done;
  assign sb = state == DB || state == BNX || state == BMEM;
  assign c = sb ? ins_r[15:10] : ins_r[9:4];
  assign dec = state == DA || state == DB;
  assign nx = state == ANX || state == BNX;
  assign mem = state == AMEM || state == BMEM;
  assign bus = nx || mem;
  assign nx_s = sb ? BNX : ANX;
  assign mem_s = sb ? BMEM : AMEM;
  // cnt counts strobe cycles already spent without ack; the timeout fires in the last allowed one
  assign tmo = BUS_TMO > 0 && bus && !ab_ack && cnt == 32'(BUS_TMO - 1);
  assign done = bus && (ab_ack || tmo);
  assign d = tmo ? 16'd0 : ab_dti;
  assign ins_rdy = state == IDLE;
  assign op_vld = state == OUT;
  assign ab_stb = bus;
  // k marks that one next word was already consumed, so the b operand reads the following word
  assign ab_adr = nx ? pc + {15'd0, k} : (mem ? adr : 16'd0);
  assign rra = dec ? c[2:0] : 3'd0;
  assign opc = ins_r[3:0];
  assign acd = ins_r[9:4];
  always_comb begin
    nxt = state;
    adr_n = adr;
    v = '0;
    fin = 1'b0;
    sp_inc = 1'b0;
    sp_dec = 1'b0;
    pc_inc = 1'b0;
    case (state)
      IDLE: nxt = ins_vld ? DA : IDLE;
      DA, DB: begin
        if (c[5]) begin
          fin = 1'b1;
          v = {11'd0, c[4:0]};
        end else if (c[4:3] == 2'd0) begin
          fin = 1'b1;
          v = rrd;
        end else if (c[4:3] != 2'd3) begin
          adr_n = rrd;
          nxt = c[4] ? nx_s : mem_s;
        end else begin
          case (c[2:0])
            3'd0: begin adr_n = sp; sp_inc = ena; nxt = mem_s; end
            3'd1: begin adr_n = sp; nxt = mem_s; end
            3'd2: begin adr_n = sp - 16'd1; sp_dec = ena; nxt = mem_s; end
            3'd3: begin fin = 1'b1; v = sp; end
            3'd4: begin fin = 1'b1; v = pc; end
            3'd5: begin fin = 1'b1; v = regO; end
            3'd6: begin adr_n = '0; nxt = nx_s; end
            default: nxt = nx_s;
          endcase
        end
      end
      ANX, BNX: begin
        if (done) begin
          pc_inc = ena;
          fin = c == 6'h1f;
          v = d;
          adr_n = adr + d;
          nxt = mem_s;
        end
      end
      AMEM, BMEM: begin
        fin = done;
        v = d;
      end
      OUT: nxt = op_rdy ? IDLE : OUT;
    endcase
    if (fin) nxt = sb ? OUT : DB;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ins_r <= '0;
      adr <= '0;
      cnt <= '0;
      k <= 1'b0;
      regA <= '0;
      regB <= '0;
      ea <= '0;
      ea_mem <= 1'b0;
      err <= 1'b0;
    end else if (ena) begin
      state <= nxt;
      adr <= adr_n;
      cnt <= (bus && !done) ? cnt + 32'd1 : '0;
      if (state == IDLE && ins_vld) begin
        ins_r <= ins;
        k <= 1'b0;
        ea <= '0;
        ea_mem <= 1'b0;
      end
      if (nx && done) k <= 1'b1;
      if (fin && sb) regB <= v;
      if (fin && !sb) regA <= v;
      if (state == AMEM && done) begin
        ea <= adr;
        ea_mem <= 1'b1;
      end
      if (tmo) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dcpu16_opf.sv
// tb_dcpu16_opf: scoreboard bench for dcpu16_opf with a behavioural operand model
module tb_dcpu16_opf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ena, ins_vld, ins_rdy, ab_stb, ab_ack, pc_inc, sp_inc, sp_dec, ea_mem, op_vld, op_rdy, err;
  logic [15:0] ins, rrd, pc, sp, o, ab_adr, ab_dti, rega, regb, ea;
  logic [2:0] rra;
  logic [3:0] opc;
  logic [5:0] acd;
  logic [15:0] rf [8];
  assign rrd = rf[rra];
  dcpu16_opf dut (
    .clk(clk), .rst(rst), .ena(ena), .ins(ins), .ins_vld(ins_vld), .ins_rdy(ins_rdy),
    .rra(rra), .rrd(rrd), .pc(pc), .sp(sp), .regO(o),
    .ab_adr(ab_adr), .ab_stb(ab_stb), .ab_ack(ab_ack), .ab_dti(ab_dti),
    .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec), .opc(opc), .regA(rega), .regB(regb),
    .ea(ea), .ea_mem(ea_mem), .acd(acd), .op_vld(op_vld), .op_rdy(op_rdy), .err(err)
  );
  logic t_rst, t_vld, t_rdy, t_stb, t_pci, t_si, t_sd, t_em, t_ovld, t_opr, t_err;
  logic [15:0] t_ins, t_rrd, t_adr, t_rega, t_regb, t_ea;
  logic [2:0] t_rra;
  logic [3:0] t_opc;
  logic [5:0] t_acd;
  assign t_rrd = 16'h4000 | {13'd0, t_rra};
  dcpu16_opf #(.BUS_TMO(4)) dut_tmo (
    .clk(clk), .rst(t_rst), .ena(1'b1), .ins(t_ins), .ins_vld(t_vld), .ins_rdy(t_rdy),
    .rra(t_rra), .rrd(t_rrd), .pc(16'h0010), .sp(16'h0200), .regO(16'h0000),
    .ab_adr(t_adr), .ab_stb(t_stb), .ab_ack(1'b0), .ab_dti(16'h0000),
    .pc_inc(t_pci), .sp_inc(t_si), .sp_dec(t_sd), .opc(t_opc), .regA(t_rega), .regB(t_regb),
    .ea(t_ea), .ea_mem(t_em), .acd(t_acd), .op_vld(t_ovld), .op_rdy(t_opr), .err(t_err)
  );
  int tests = 0, fails = 0, fw = -1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  logic [15:0] ov [logic [15:0]];
  function automatic logic [15:0] memv(input logic [15:0] a);
    return ov.exists(a) ? ov[a] : (a * 16'h9E37) ^ 16'h5A5A;
  endfunction
  logic [15:0] adr_q [$];
  function automatic logic [15:0] rd(input logic [15:0] a);
    adr_q.push_back(a);
    return memv(a);
  endfunction
  function automatic void res(input logic [5:0] c, inout int k, output logic [15:0] v,
                              output logic [15:0] a, output logic m, inout int si, inout int sd);
    m = 1'b0;
    a = '0;
    if (c >= 6'h20) v = 16'(c - 6'h20);
    else if (c < 6'h08) v = rf[c[2:0]];
    else if (c == 6'h1b) v = sp;
    else if (c == 6'h1c) v = pc;
    else if (c == 6'h1d) v = o;
    else if (c == 6'h1f) begin v = rd(pc + 16'(k)); k++; end
    else begin
      m = 1'b1;
      if (c < 6'h10) a = rf[c[2:0]];
      else if (c < 6'h18) begin a = rd(pc + 16'(k)) + rf[c[2:0]]; k++; end
      else if (c == 6'h1e) begin a = rd(pc + 16'(k)); k++; end
      else begin
        a = (c == 6'h1a) ? sp - 16'd1 : sp;
        si += int'(c == 6'h18);
        sd += int'(c == 6'h1a);
      end
      v = rd(a);
    end
  endfunction
  typedef struct {
    logic [3:0] opc;
    logic [5:0] acd;
    logic [15:0] a, b, ea;
    logic em;
    int pci, si, sd;
  } exp_t;
  exp_t exp_q [$];
  task automatic issue(input logic [15:0] w);
    exp_t e;
    int k;
    logic [15:0] ja;
    logic jm;
    k = 0;
    e.si = 0;
    e.sd = 0;
    e.opc = w[3:0];
    e.acd = w[9:4];
    res(w[9:4], k, e.a, e.ea, e.em, e.si, e.sd);
    res(w[15:10], k, e.b, ja, jm, e.si, e.sd);
    e.pci = k;
    exp_q.push_back(e);
    ins = w;
    ins_vld = 1'b1;
    @(posedge clk); #1;
    ins_vld = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (!ins_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ins_rdy) chk("idle_wait", ins_rdy, 1);
  endtask
  task automatic rnd_env();
    foreach (rf[i]) rf[i] = 16'($urandom);
    pc = 16'($urandom);
    sp = 16'($urandom);
    o = 16'($urandom);
  endtask
  initial begin : slave
    int w, len;
    w = -1;
    len = 0;
    ab_ack = 1'b0;
    ab_dti = '0;
    forever begin
      @(posedge clk); #1;
      ab_ack = 1'b0;
      if (rst) begin
        w = -1;
        len = 0;
      end else if (ab_stb) begin
        len++;
        if (w < 0) w = (fw >= 0) ? fw : int'($urandom_range(0, 2));
        if (w == 0) begin
          ab_ack = 1'b1;
          ab_dti = memv(ab_adr);
          if (fw >= 0) chk("stb_hold", len, fw + 1);
          if (adr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_adr: unexpected read at %0h", ab_adr);
          end else chk("bus_adr", ab_adr, adr_q.pop_front());
          w = -1;
          len = 0;
        end else w--;
      end else begin
        ab_ack = $urandom_range(0, 7) == 0;
        ab_dti = 16'hDEAD;
      end
    end
  end
  initial begin : rdy_drv
    op_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      op_rdy = $urandom_range(0, 2) != 0;
    end
  end
  initial begin : mon
    exp_t e;
    int cyc, t0, stbn, pci, si, sd;
    bit seen, hold;
    logic [63:0] snap, cur;
    cyc = 0; t0 = 0; stbn = 0; pci = 0; si = 0; sd = 0; seen = 1'b1; hold = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (ins_vld && ins_rdy) begin
          t0 = cyc; stbn = 0; pci = 0; si = 0; sd = 0; seen = 1'b0; hold = 1'b0;
        end
        stbn += int'(ab_stb);
        pci += int'(pc_inc);
        si += int'(sp_inc);
        sd += int'(sp_dec);
        cur = {5'd0, rega, regb, ea, ea_mem, opc, acd};
        if (op_vld) begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - t0, 3 + stbn);
          end
          if (hold) begin
            chk("out_stable", cur, snap);
            chk("ins_rdy_in_out", ins_rdy, 0);
          end
          if (op_rdy) begin
            hold = 1'b0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL scoreboard: op_vld with nothing expected");
            end else begin
              e = exp_q.pop_front();
              chk("opc", opc, e.opc);
              chk("acd", acd, e.acd);
              chk("regA", rega, e.a);
              chk("regB", regb, e.b);
              chk("ea_mem", ea_mem, e.em);
              chk("ea", ea, e.ea);
              chk("pc_inc_cnt", pci, e.pci);
              chk("sp_inc_cnt", si, e.si);
              chk("sp_dec_cnt", sd, e.sd);
            end
          end else begin
            hold = 1'b1;
            snap = cur;
          end
        end
      end
    end
  end
  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin : main
    int n, stbc;
    rst = 1'b1; t_rst = 1'b1; ena = 1'b1;
    ins = '0; ins_vld = 1'b0; pc = '0; sp = '0; o = '0;
    foreach (rf[i]) rf[i] = '0;
    t_ins = '0; t_vld = 1'b0; t_opr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {ins_rdy, op_vld, ab_stb, pc_inc, sp_inc, sp_dec, ea_mem, err}, 8'b1000_0000);
    chk("rst_rra", rra, 0);
    chk("rst_regs", {rega, regb, ea, ab_adr}, 64'd0);
    chk("rst_opc_acd", {opc, acd}, 0);
    chk("rst_tmo_err", t_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    t_rst = 1'b0;
    wait_idle(); rnd_env(); issue(16'hFC01);
    wait_idle(); rnd_env(); pc = 16'h0010;
    ov[16'h0010] = 16'h1000; ov[16'h0011] = 16'h1234; ov[16'h1000] = 16'h0005;
    issue(16'h7DE2);
    wait_idle(); rf[1] = 16'hFFFF; pc = 16'h0020; ov[16'h0020] = 16'h0002; fw = 4;
    issue(16'h8111);
    wait_idle(); fw = -1; sp = 16'h0100;
    issue(16'h61A1);
    repeat (150) begin
      wait_idle();
      rnd_env();
      issue(16'($urandom));
    end
    wait_idle();
    repeat (3) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    chk("adr_drain", adr_q.size(), 0);
    @(posedge clk); #1;
    t_ins = 16'h8481;
    t_vld = 1'b1;
    @(posedge clk); #1;
    t_vld = 1'b0;
    n = 0;
    stbc = 0;
    while (!t_ovld && n < 50) begin
      @(negedge clk);
      if (t_stb) begin
        stbc++;
        if (stbc == 1) chk("tmo_err_early", t_err, 0);
      end
      n++;
    end
    chk("tmo_op_vld", t_ovld, 1);
    chk("tmo_stb_cycles", stbc, 4);
    chk("tmo_err", t_err, 1);
    chk("tmo_regA", t_rega, 0);
    chk("tmo_regB", t_regb, 1);
    chk("tmo_ea", {t_em, t_ea}, 17'h1_4000);
    @(posedge clk); #1;
    t_opr = 1'b1;
    @(posedge clk); #1;
    t_opr = 1'b0;
    t_vld = 1'b1;
    @(posedge clk); #1;
    t_vld = 1'b0;
    n = 0;
    while (!t_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_stb_before", t_stb, 1);
    t_rst = 1'b1;
    #1;
    chk("rst_mid_stb", t_stb, 0);
    chk("rst_mid_rdy", t_rdy, 1);
    chk("rst_mid_err", t_err, 0);
    @(posedge clk); #1;
    t_rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
